vector_exec_wb: RTL

Execute/memory/writeback back-end of the vectorial encryption CPU. Consumes the decode-stage execute bundle (four 16-bit lane operand pairs, scalar operands, control) and runs a 4-lane 16-bit ALU. It issues vector stores to data memory and maintains the loop counter. It returns the writeback bundle (lane results, destination register, write enable, counter update, zero flag) to the decode/register-file stage, closing the pipeline loop.

---
 rtl/vector_exec_wb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vector_exec_wb.sv
// ---------------------------------------------------------------------------
// vector_exec_wb
//
// Execute / memory / writeback back-end of the vectorial encryption CPU.
// Takes the decode-stage execute bundle, runs four independent 16-bit lane
// ALUs, issues vector stores to data memory, computes the loop-counter
// update and hands the writeback bundle back to the decode/register-file
// stage.
//
// Pipeline: E bundle -> EX/MEM register -> MEM/WB register.
//   Store strobe/address/data come straight out of EX/MEM (1-cycle latency).
//   Lane results, destination, counter update and zeroFlag come out of
//   MEM/WB (2-cycle latency).
//
// Configuration macro: VEC_ROT_EN
//   defined   : ALU op 110 is a per-lane rotate-left by dataOp2[3:0]
//   undefined : no rotator is built, op 110 behaves as 111 (pass B)
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   RDx1E / RDx2E            lane 0..3 operands A / B
//   dataOp1                  store address / counter source
//   dataOp2                  shift / rotate amount in [3:0]
//   RdE, regWriteE           destination register and its write enable
//   memWriteE                store the four operand-B lanes
//   updateCnt                decrement the loop counter
//   aluControlE              lane ALU operation
//   memWe, memAddr, memWdata store strobe, address, data (lane 3 on top)
//   regWriteWB, RdestW       register-file write enable and address
//   res0..res3               lane results
//   updateCount, resCount    counter write enable and new counter value
//   zeroFlag                 registered, sticky counter-zero flag
// ---------------------------------------------------------------------------
module vector_exec_wb #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       RD01E,
    input  logic [15:0]       RD11E,
    input  logic [15:0]       RD21E,
    input  logic [15:0]       RD31E,
    input  logic [15:0]       RD02E,
    input  logic [15:0]       RD12E,
    input  logic [15:0]       RD22E,
    input  logic [15:0]       RD32E,
    input  logic [15:0]       dataOp1,
    input  logic [15:0]       dataOp2,
    input  logic [3:0]        RdE,
    input  logic              regWriteE,
    input  logic              memWriteE,
    input  logic              updateCnt,
    input  logic [2:0]        aluControlE,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [63:0]       memWdata,
    output logic              regWriteWB,
    output logic [3:0]        RdestW,
    output logic [15:0]       res0,
    output logic [15:0]       res1,
    output logic [15:0]       res2,
    output logic [15:0]       res3,
    output logic              updateCount,
    output logic [15:0]       resCount,
    output logic              zeroFlag
);

    // One lane of the ALU; every lane is identical and independent.
    function automatic logic [15:0] alu_lane(
        input logic [2:0]  op,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [3:0]  amt
    );
        logic [15:0] r;
`ifdef VEC_ROT_EN
        logic [31:0] rot;
        // Rotating the doubled word keeps amount 0 well defined (no 16-bit
        // right shift, which would otherwise be needed for the wrap part).
        rot = {a, a} << amt;
`endif
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a ^ b;
            3'b011:  r = a & b;
            3'b100:  r = a | b;
            3'b101:  r = a << amt;
`ifdef VEC_ROT_EN
            3'b110:  r = rot[31:16];
`else
            3'b110:  r = b;
`endif
            default: r = b;
        endcase
        return r;
    endfunction

    logic [15:0] lane_a   [4];
    logic [15:0] lane_b   [4];
    logic [15:0] lane_res [4];

    // Only the low ADDR_W bits of the address and the low nibble of the
    // shift amount are architecturally meaningful.
    logic unused_bits;
    assign unused_bits = ^{dataOp1[15:ADDR_W], dataOp2[15:4]};

    // Lane ALUs
    always_comb begin
        lane_a[0] = RD01E;
        lane_a[1] = RD11E;
        lane_a[2] = RD21E;
        lane_a[3] = RD31E;
        lane_b[0] = RD02E;
        lane_b[1] = RD12E;
        lane_b[2] = RD22E;
        lane_b[3] = RD32E;
        for (int i = 0; i < 4; i++) begin
            lane_res[i] = alu_lane(aluControlE, lane_a[i], lane_b[i], dataOp2[3:0]);
        end
    end

    // EX/MEM stage state
    logic        exm_reg_write;
    logic [3:0]  exm_rd;
    logic [15:0] exm_res [4];
    logic        exm_update;
    logic [15:0] exm_cnt;

    // EX/MEM register. Strobes are captured every cycle so bubbles clear
    // them; payloads only load when their strobe is set and otherwise hold.
    // The store port is driven directly from this stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exm_reg_write <= 1'b0;
            exm_rd        <= '0;
            exm_update    <= 1'b0;
            exm_cnt       <= '0;
            memWe         <= 1'b0;
            memAddr       <= '0;
            memWdata      <= '0;
            for (int i = 0; i < 4; i++) begin
                exm_res[i] <= '0;
            end
        end else begin
            exm_reg_write <= regWriteE;
            exm_update    <= updateCnt;
            memWe         <= memWriteE;
            if (regWriteE) begin
                exm_rd <= RdE;
                for (int i = 0; i < 4; i++) begin
                    exm_res[i] <= lane_res[i];
                end
            end
            if (updateCnt) begin
                exm_cnt <= dataOp1 - 16'd1;
            end
            if (memWriteE) begin
                memAddr  <= dataOp1[ADDR_W-1:0];
                memWdata <= {RD32E, RD22E, RD12E, RD02E};
            end
        end
    end

    // MEM/WB register. Results and destination hold across bubbles with
    // regWriteWB low. zeroFlag is only refreshed together with a counter
    // update, which makes it sticky between updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regWriteWB  <= 1'b0;
            RdestW      <= '0;
            res0        <= '0;
            res1        <= '0;
            res2        <= '0;
            res3        <= '0;
            updateCount <= 1'b0;
            resCount    <= '0;
            zeroFlag    <= 1'b0;
        end else begin
            regWriteWB  <= exm_reg_write;
            updateCount <= exm_update;
            if (exm_reg_write) begin
                RdestW <= exm_rd;
                res0   <= exm_res[0];
                res1   <= exm_res[1];
                res2   <= exm_res[2];
                res3   <= exm_res[3];
            end
            if (exm_update) begin
                resCount <= exm_cnt;
                zeroFlag <= (exm_cnt == 16'd0);
            end
        end
    end

endmodule
